// File: rtl/ddr_dfi_traffic_gen.sv
// ddr_dfi_traffic_gen
//   DFI-clock-domain traffic detector for the PHY write/command clock gating.
//   Per-phase cs / wrdata_en / wck_en are collapsed to one bit per dfi cycle
//   and run through shift-register delay lines. Latency taps on those lines
//   give level enables for the CA, DQ and DQS clocks. A stop/wake FSM driven
//   by dfi_dram_clk_disable sequences the CK enable.
//
//   Ports
//   i_clk, i_rst_n           dfi clock, synchronous active-low reset
//   i_dfi_cs                 per-phase chip select
//   i_dfi_wrdata_en          per-phase write data enable
//   i_dfi_wck_en             per-phase WCK enable
//   i_dfi_dram_clk_disable   request to stop CK
//   i_ca_lat / i_wr_lat      CA / DQ enable delay in dfi cycles
//   i_dqs_pre                DQS pre-assert cycles ahead of DQ
//   i_ck_stop_dly            idle cycles before CK stops
//   i_ck_wake_dly            CK run cycles after wake before RUN
//   o_ca_clk_en, o_dq_wrclk_en, o_dqs_wrclk_en, o_ck_clk_en   clock enables
//   o_ck_stopped             CK FSM is in STOP
//   o_cs_err                 sticky: cs seen while CK stopped
//
//   state | meaning
//   STOP  | CK gated; waiting for disable release or stray cs
//   WAKE  | CK running, counting wake delay before normal operation
//   RUN   | normal operation
//   DRAIN | disable requested and idle; counting down before STOP

module ddr_dfi_traffic_gen #(
    parameter int NUM_PH = 4,
    parameter int LAT_W  = 3,
    parameter int DLY_W  = 8
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [NUM_PH-1:0] i_dfi_cs,
    input  logic [NUM_PH-1:0] i_dfi_wrdata_en,
    input  logic [NUM_PH-1:0] i_dfi_wck_en,
    input  logic              i_dfi_dram_clk_disable,
    input  logic [LAT_W-1:0]  i_ca_lat,
    input  logic [LAT_W-1:0]  i_wr_lat,
    input  logic [LAT_W-1:0]  i_dqs_pre,
    input  logic [DLY_W-1:0]  i_ck_stop_dly,
    input  logic [DLY_W-1:0]  i_ck_wake_dly,
    output logic              o_ca_clk_en,
    output logic              o_dq_wrclk_en,
    output logic              o_dqs_wrclk_en,
    output logic              o_ck_clk_en,
    output logic              o_ck_stopped,
    output logic              o_cs_err
);

    localparam int DEPTH = 2 ** LAT_W;

    typedef enum logic [1:0] {
        ST_STOP  = 2'd0,
        ST_WAKE  = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } ck_state_t;

    ck_state_t        state;
    logic [DLY_W-1:0] cnt;
    logic [DEPTH-1:0] c_line;
    logic [DEPTH-1:0] w_line;
    logic [DEPTH-1:0] k_line;
    logic             cs_any;
    logic             ca_busy;
    logic [LAT_W-1:0] dqs_lo;
    logic             dqs_win;

    assign cs_any  = |i_dfi_cs;
    assign ca_busy = (|c_line) | cs_any;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            c_line <= '0;
            w_line <= '0;
            k_line <= '0;
        end else begin
            c_line <= {c_line[DEPTH-2:0], cs_any};
            w_line <= {w_line[DEPTH-2:0], |i_dfi_wrdata_en};
            k_line <= {k_line[DEPTH-2:0], |i_dfi_wck_en};
        end
    end

    // Taps are plain muxes onto the line registers: stage L carries an
    // event L+1 cycles after it was presented.
    assign o_ca_clk_en   = c_line[i_ca_lat];
    assign o_dq_wrclk_en = w_line[i_wr_lat];

    // DQS opens i_dqs_pre cycles ahead of DQ; the window bottoms out at
    // stage 0 when the preamble is longer than the write latency.
    assign dqs_lo = (i_dqs_pre > i_wr_lat) ? '0 : (i_wr_lat - i_dqs_pre);

    always_comb begin
        dqs_win = 1'b0;
        for (int j = 0; j < DEPTH; j++) begin
            if ((LAT_W'(j) >= dqs_lo) && (LAT_W'(j) <= i_wr_lat)) begin
                dqs_win = dqs_win | w_line[j];
            end
        end
    end

    assign o_dqs_wrclk_en = k_line[i_wr_lat] | dqs_win;
    assign o_ck_clk_en    = (state != ST_STOP) | o_ca_clk_en;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state        <= ST_STOP;
            cnt          <= '0;
            o_ck_stopped <= 1'b1;
            o_cs_err     <= 1'b0;
        end else begin
            case (state)
                ST_RUN: begin
                    if (i_dfi_dram_clk_disable && !ca_busy) begin
                        state <= ST_DRAIN;
                        cnt   <= i_ck_stop_dly;
                    end
                end
                ST_DRAIN: begin
                    if (!i_dfi_dram_clk_disable || ca_busy) begin
                        state <= ST_RUN;
                    end else if (cnt == '0) begin
                        state        <= ST_STOP;
                        o_ck_stopped <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_STOP: begin
                    // A command while CK is gated is an error, but the
                    // clock is restarted anyway so the DRAM can see it.
                    if (cs_any) begin
                        o_cs_err <= 1'b1;
                    end
                    if (cs_any || !i_dfi_dram_clk_disable) begin
                        state        <= ST_WAKE;
                        cnt          <= i_ck_wake_dly;
                        o_ck_stopped <= 1'b0;
                    end
                end
                ST_WAKE: begin
                    if (cnt == '0) begin
                        state <= ST_RUN;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state        <= ST_STOP;
                    o_ck_stopped <= 1'b1;
                end
            endcase
        end
    end

endmodule
